// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between fetch and mem_ctrl.
// A hit answers one cycle after the request; a miss fills the word with four byte reads, lowest address first.
module icache #(
    parameter int IDX_W = 6
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_addr,
    output logic        fetch_ready,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_grant,
    input  logic [7:0]  mem_din,
    output logic [1:0]  dbg_state_o
);

    localparam int LINES = 1 << IDX_W;
    localparam int TAG_W = 16 - IDX_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RESP = 2'd2
    } state_e;

    // Handshake: a request is taken when fetch_valid & fetch_ready & rdy_in & ~clear;
    // a byte read is issued when mem_req & mem_grant, and its data is on mem_din one cycle later.

    state_e            state_q, state_d;
    logic [29:0]       pc_q, pc_d;
    logic [2:0]        iss_q, iss_d;
    logic [2:0]        rcv_q, rcv_d;
    logic              cap_q, cap_d;
    logic [31:0]       line_q, line_d;
    logic              inst_valid_q, inst_valid_d;
    logic [31:0]       inst_q, inst_d;
    logic [31:0]       inst_pc_q, inst_pc_d;

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [31:0]       data_q [LINES];

    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;
    logic              hit;
    logic              accept;
    logic              wr_en;
    logic              unused_addr_bits;

    assign req_idx  = fetch_addr[IDX_W+1:2];
    assign req_tag  = fetch_addr[17:IDX_W+2];
    assign fill_idx = pc_q[IDX_W-1:0];
    assign fill_tag = pc_q[15:IDX_W];
    assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign accept   = (state_q == S_IDLE) && fetch_valid && !clear && rdy_in;
    assign unused_addr_bits = ^fetch_addr[1:0];

    assign fetch_ready = (state_q == S_IDLE);
    assign inst_valid  = inst_valid_q;
    assign inst        = inst_q;
    assign inst_pc     = inst_pc_q;
    assign dbg_state_o = state_q;
    assign mem_req     = (state_q == S_FILL) && (iss_q < 3'd4) && rdy_in;
    assign mem_addr    = (state_q == S_FILL) ? ({pc_q, 2'b00} + {29'd0, iss_q}) : 32'd0;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        iss_d        = iss_q;
        rcv_d        = rcv_q;
        cap_d        = 1'b0;
        line_d       = line_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        wr_en        = 1'b0;

        // A byte granted last cycle lands even if rdy_in has just dropped.
        if (cap_q) begin
            line_d[{rcv_q[1:0], 3'b000} +: 8] = mem_din;
            rcv_d = rcv_q + 3'd1;
        end

        if (clear) begin
            state_d      = S_IDLE;
            iss_d        = 3'd0;
            rcv_d        = 3'd0;
            inst_valid_d = 1'b0;
        end else if (rdy_in) begin
            case (state_q)
                S_IDLE: begin
                    inst_valid_d = 1'b0;
                    if (accept) begin
                        pc_d = fetch_addr[31:2];
                        if (hit) begin
                            inst_valid_d = 1'b1;
                            inst_d       = data_q[req_idx];
                            inst_pc_d    = {fetch_addr[31:2], 2'b00};
                        end else begin
                            state_d = S_FILL;
                            iss_d   = 3'd0;
                            rcv_d   = 3'd0;
                            line_d  = 32'd0;
                        end
                    end
                end
                S_FILL: begin
                    if (mem_req && mem_grant) begin
                        iss_d = iss_q + 3'd1;
                        cap_d = 1'b1;
                    end
                    if (rcv_d == 3'd4) begin
                        wr_en        = 1'b1;
                        state_d      = S_RESP;
                        iss_d        = 3'd0;
                        rcv_d        = 3'd0;
                        inst_valid_d = 1'b1;
                        inst_d       = line_d;
                        inst_pc_d    = {pc_q, 2'b00};
                    end
                end
                S_RESP: begin
                    inst_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= S_IDLE;
            pc_q         <= 30'd0;
            iss_q        <= 3'd0;
            rcv_q        <= 3'd0;
            cap_q        <= 1'b0;
            line_q       <= 32'd0;
            inst_valid_q <= 1'b0;
            inst_q       <= 32'd0;
            inst_pc_q    <= 32'd0;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            iss_q        <= iss_d;
            rcv_q        <= rcv_d;
            cap_q        <= cap_d;
            line_q       <= line_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            if (wr_en) begin
                valid_q[fill_idx] <= 1'b1;
            end
        end
    end

    // Tag and data storage needs no reset: valid_q gates every use.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= line_d;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cycle-accurate fill timing, hits, stalls, rdy_in freeze and clear.
module tb_icache;

  localparam int NCYC = 12;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear;
  logic        fetch_valid;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_grant;
  logic [7:0]  mem_din = 8'h00;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  logic        log_req   [NCYC];
  logic [31:0] log_addr  [NCYC];
  logic        log_iv    [NCYC];
  logic [31:0] log_inst  [NCYC];
  logic [31:0] log_pc    [NCYC];
  logic        log_fr    [NCYC];
  logic [1:0]  log_state [NCYC];

  logic [31:0] exp_q [$];

  icache #(.IDX_W(6)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .clear       (clear),
    .fetch_valid (fetch_valid),
    .fetch_addr  (fetch_addr),
    .fetch_ready (fetch_ready),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_grant   (mem_grant),
    .mem_din     (mem_din),
    .dbg_state_o (dbg_state)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] w;
    case ({a[31:2], 2'b00})
      32'h0000_0000: w = 32'h0000_0513;
      32'h0000_0100: w = 32'h00a0_0093;
      32'h0000_0040: w = 32'h1234_5678;
      32'h0000_0080: w = 32'hdead_beef;
      32'h0000_00c0: w = 32'hcafe_f00d;
      default:       w = 32'h0000_0000;
    endcase
    return w[{a[1:0], 3'b000} +: 8];
  endfunction

  // mem_ctrl model: a granted byte read returns its data one cycle later.
  always @(posedge clk_in) begin
    if (mem_req && mem_grant) mem_din <= mem_byte(mem_addr);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Cycle 0 is the cycle in which the first request is presented.
  task automatic run_fetch(input logic [31:0] a0, input logic two, input logic [31:0] a1,
                           input logic [15:0] ng, input logic [15:0] nr, input int clr_at);
    for (int k = 0; k < NCYC; k++) begin
      @(posedge clk_in);
      #2;
      fetch_valid = (k == 0) || (two && k == 1);
      fetch_addr  = (two && k == 1) ? a1 : a0;
      mem_grant   = ~ng[k];
      rdy_in      = ~nr[k];
      clear       = (k == clr_at);
      #1;
      log_req[k]   = mem_req;
      log_addr[k]  = mem_addr;
      log_iv[k]    = inst_valid;
      log_inst[k]  = inst;
      log_pc[k]    = inst_pc;
      log_fr[k]    = fetch_ready;
      log_state[k] = dbg_state;
    end
    fetch_valid = 1'b0;
    clear       = 1'b0;
    rdy_in      = 1'b1;
    mem_grant   = 1'b1;
  endtask

  function automatic int first_iv();
    for (int k = 0; k < NCYC; k++) if (log_iv[k]) return k;
    return -1;
  endfunction

  function automatic int count_iv();
    int n = 0;
    for (int k = 0; k < NCYC; k++) if (log_iv[k]) n++;
    return n;
  endfunction

  function automatic int count_req();
    int n = 0;
    for (int k = 0; k < NCYC; k++) if (log_req[k]) n++;
    return n;
  endfunction

  task automatic check_resp(input string tag, input int exp_cyc, input logic [31:0] exp_inst,
                            input logic [31:0] exp_pc);
    int f;
    f = first_iv();
    check_eq({tag, "_iv_cycle"}, f, exp_cyc);
    check_eq({tag, "_iv_count"}, count_iv(), 1);
    check_eq({tag, "_inst"}, (f >= 0) ? log_inst[f] : 32'hffff_ffff, exp_inst);
    check_eq({tag, "_pc"}, (f >= 0) ? log_pc[f] : 32'hffff_ffff, exp_pc);
  endtask

  initial begin
    rst_in      = 1'b1;
    rdy_in      = 1'b1;
    clear       = 1'b0;
    fetch_valid = 1'b0;
    fetch_addr  = 32'd0;
    mem_grant   = 1'b1;
    #12;
    check_eq("rst_fetch_ready", fetch_ready, 1);
    check_eq("rst_inst_valid", inst_valid, 0);
    check_eq("rst_inst", inst, 0);
    check_eq("rst_inst_pc", inst_pc, 0);
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_state", dbg_state, 0);
    @(negedge clk_in);
    rst_in = 1'b0;

    // cold miss at 0x0000, grant always high
    run_fetch(32'h0, 1'b0, 32'h0, 16'h0, 16'h0, -1);
    for (int i = 0; i < 4; i++) exp_q.push_back(i);
    check_eq("t1_req_c0", log_req[0], 0);
    for (int k = 1; k <= 4; k++) begin
      check_eq($sformatf("t1_req_c%0d", k), log_req[k], 1);
      check_eq($sformatf("t1_addr_c%0d", k), log_addr[k], exp_q.pop_front());
    end
    check_eq("t1_req_c5", log_req[5], 0);
    check_eq("t1_ready_c1", log_fr[1], 0);
    check_eq("t1_state_c1", log_state[1], 1);
    check_eq("t1_state_c6", log_state[6], 2);
    check_resp("t1", 6, 32'h0000_0513, 32'h0);
    check_eq("t1_ready_c7", log_fr[7], 1);

    // refetch hits
    run_fetch(32'h0, 1'b0, 32'h0, 16'h0, 16'h0, -1);
    check_resp("t2", 1, 32'h0000_0513, 32'h0);
    check_eq("t2_req_count", count_req(), 0);

    // conflict on index 0
    run_fetch(32'h100, 1'b0, 32'h0, 16'h0, 16'h0, -1);
    check_eq("t3a_req_count", count_req(), 4);
    check_eq("t3a_addr_c1", log_addr[1], 32'h100);
    check_resp("t3a", 6, 32'h00a0_0093, 32'h100);
    run_fetch(32'h0, 1'b0, 32'h0, 16'h0, 16'h0, -1);
    check_eq("t3b_req_count", count_req(), 4);
    check_resp("t3b", 6, 32'h0000_0513, 32'h0);

    // grant withheld in cycles 2-3
    run_fetch(32'h40, 1'b0, 32'h0, 16'h000c, 16'h0, -1);
    check_eq("t4_addr_c2", log_addr[2], 32'h41);
    check_eq("t4_addr_c3", log_addr[3], 32'h41);
    check_eq("t4_req_c3", log_req[3], 1);
    check_eq("t4_addr_c4", log_addr[4], 32'h41);
    check_eq("t4_addr_c6", log_addr[6], 32'h43);
    check_eq("t4_req_count", count_req(), 6);
    check_resp("t4", 8, 32'h1234_5678, 32'h40);

    // back-to-back hits
    run_fetch(32'h0, 1'b1, 32'h40, 16'h0, 16'h0, -1);
    check_eq("b2b_iv_c1", log_iv[1], 1);
    check_eq("b2b_inst_c1", log_inst[1], 32'h0000_0513);
    check_eq("b2b_iv_c2", log_iv[2], 1);
    check_eq("b2b_inst_c2", log_inst[2], 32'h1234_5678);
    check_eq("b2b_pc_c2", log_pc[2], 32'h40);
    check_eq("b2b_iv_count", count_iv(), 2);

    // clear in cycle 3 of a fill
    run_fetch(32'h80, 1'b0, 32'h0, 16'h0, 16'h0, 3);
    check_eq("t5_req_c3", log_req[3], 1);
    check_eq("t5_req_c4", log_req[4], 0);
    check_eq("t5_ready_c4", log_fr[4], 1);
    check_eq("t5_iv_count", count_iv(), 0);
    run_fetch(32'h80, 1'b0, 32'h0, 16'h0, 16'h0, -1);
    check_eq("t5b_req_count", count_req(), 4);
    check_resp("t5b", 6, 32'hdead_beef, 32'h80);

    // rdy_in low in cycles 2-4
    run_fetch(32'hc0, 1'b0, 32'h0, 16'h0, 16'h001c, -1);
    check_eq("t6_req_c1", log_req[1], 1);
    check_eq("t6_req_c2", log_req[2], 0);
    check_eq("t6_req_c4", log_req[4], 0);
    check_eq("t6_addr_c5", log_addr[5], 32'hc1);
    check_eq("t6_req_count", count_req(), 4);
    check_resp("t6", 9, 32'hcafe_f00d, 32'hc0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
